// File: rtl/audio_clock_regeneration_receiver.sv
// ACR packet receiver: parses N/CTS packets and drives an N/CTS DDS audio clock enable.
// Optional ACR_SUBPACKET_CHECK_EN: require subpackets 1..3 to repeat subpacket 0 exactly.
module audio_clock_regeneration_receiver #(
    parameter int unsigned MAX_GAP = 64
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        pkt_valid,
    input  logic        pkt_start,
    input  logic [7:0]  pkt_data,
    output logic        acr_valid,
    output logic [19:0] n_out,
    output logic [19:0] cts_out,
    output logic        acr_error,
    output logic        clk_audio_en
);
    localparam int unsigned IDX_W = 5;
    localparam int unsigned POS_W = 3;
    localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);
    localparam int unsigned VAL_W = 20;
    localparam int unsigned ACC_W = 21;
    localparam logic [IDX_W-1:0] LAST_HDR_IDX = IDX_W'(2);
    localparam logic [IDX_W-1:0] SUB1_IDX     = IDX_W'(10);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(30);
    localparam logic [POS_W-1:0] LAST_POS     = POS_W'(6);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(MAX_GAP - 1);

    typedef enum logic [2:0] {IDLE, HEADER, SUB, SKIP, REPORT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               bad_q, bad_d;
    logic [VAL_W-1:0]   n_cap_q, n_cap_d, cts_cap_q, cts_cap_d;
    logic               acr_valid_q, acr_valid_d, acr_error_q, acr_error_d;
    logic [VAL_W-1:0]   n_out_q, n_out_d, cts_out_q, cts_out_d;
    logic               active_q, active_d;
    logic [VAL_W-1:0]   dds_n_q, dds_n_d, dds_cts_q, dds_cts_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               en_q, en_d;

    logic               start_c, in_pkt_c, gap_expire_c, last_c, range_ok_c, keep_c, en_step_c;
    logic [ACC_W-1:0]   sum_c, acc_step_c;

    assign start_c      = pkt_valid & pkt_start;
    assign in_pkt_c     = (state_q == HEADER) || (state_q == SUB);
    assign gap_expire_c = in_pkt_c && !pkt_valid && (gap_q == GAP_LAST);
    assign last_c       = (state_q == SUB) && pkt_valid && !pkt_start && (idx_q == LAST_IDX);
    assign range_ok_c   = (n_cap_q != '0) && (cts_cap_q != '0) && (n_cap_q < cts_cap_q);

`ifdef ACR_SUBPACKET_CHECK_EN
    // Byte expected at the current subpacket position, rebuilt from subpacket 0.
    logic [7:0] ref_byte_c;
    always_comb begin
        case (pos_q)
            3'd1:    ref_byte_c = {4'h0, cts_cap_q[19:16]};
            3'd2:    ref_byte_c = cts_cap_q[15:8];
            3'd3:    ref_byte_c = cts_cap_q[7:0];
            3'd4:    ref_byte_c = {4'h0, n_cap_q[19:16]};
            3'd5:    ref_byte_c = n_cap_q[15:8];
            3'd6:    ref_byte_c = n_cap_q[7:0];
            default: ref_byte_c = 8'h00;
        endcase
    end
`endif

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = (pkt_data == 8'h01) ? HEADER : SKIP;
        end else begin
            case (state_q)
                HEADER: begin
                    if (pkt_valid && idx_q == LAST_HDR_IDX) state_d = SUB;
                    else if (gap_expire_c)                  state_d = IDLE;
                end
                SUB: begin
                    if (last_c)            state_d = REPORT;
                    else if (gap_expire_c) state_d = IDLE;
                end
                REPORT:  state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Byte capture, packet checks and the report/abort pulses.
    always_comb begin
        idx_d       = idx_q;
        pos_d       = pos_q;
        gap_d       = gap_q;
        bad_d       = bad_q;
        n_cap_d     = n_cap_q;
        cts_cap_d   = cts_cap_q;
        acr_valid_d = 1'b0;
        acr_error_d = 1'b0;
        n_out_d     = n_out_q;
        cts_out_d   = cts_out_q;
        if (start_c) begin
            idx_d = IDX_W'(1);
            pos_d = '0;
            gap_d = '0;
            bad_d = 1'b0;
        end else if (in_pkt_c) begin
            if (pkt_valid) begin
                gap_d = '0;
                idx_d = idx_q + IDX_W'(1);
                if (state_q == SUB) begin
                    pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
                    if (idx_q < SUB1_IDX) begin
                        case (pos_q)
                            3'd0: if (pkt_data != 8'h00) bad_d = 1'b1;
                            3'd1: begin
                                if (pkt_data[7:4] != 4'h0) bad_d = 1'b1;
                                cts_cap_d[19:16] = pkt_data[3:0];
                            end
                            3'd2: cts_cap_d[15:8] = pkt_data;
                            3'd3: cts_cap_d[7:0]  = pkt_data;
                            3'd4: begin
                                if (pkt_data[7:4] != 4'h0) bad_d = 1'b1;
                                n_cap_d[19:16] = pkt_data[3:0];
                            end
                            3'd5: n_cap_d[15:8] = pkt_data;
                            3'd6: n_cap_d[7:0]  = pkt_data;
                            default: bad_d = bad_q;
                        endcase
                    end
`ifdef ACR_SUBPACKET_CHECK_EN
                    else if (pkt_data != ref_byte_c) begin
                        bad_d = 1'b1;
                    end
`endif
                end
                if (last_c) begin
                    acr_valid_d = ~bad_d & range_ok_c;
                    acr_error_d = ~acr_valid_d;
                    if (acr_valid_d) begin
                        n_out_d   = n_cap_q;
                        cts_out_d = cts_cap_q;
                    end
                end
            end else if (gap_expire_c) begin
                gap_d       = '0;
                acr_error_d = 1'b1;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    // One DDS step: acc < CTS and N < CTS keep the sum within 21 bits.
    always_comb begin
        sum_c = acc_q + ACC_W'(dds_n_q);
        if (sum_c >= ACC_W'(dds_cts_q)) begin
            acc_step_c = sum_c - ACC_W'(dds_cts_q);
            en_step_c  = 1'b1;
        end else begin
            acc_step_c = sum_c;
            en_step_c  = 1'b0;
        end
    end

    assign keep_c = active_q && (n_out_q == dds_n_q) && (cts_out_q == dds_cts_q);

    always_comb begin
        active_d  = active_q;
        dds_n_d   = dds_n_q;
        dds_cts_d = dds_cts_q;
        acc_d     = acc_q;
        en_d      = 1'b0;
        if (active_q) begin
            acc_d = acc_step_c;
            en_d  = en_step_c;
        end
        if (acr_valid_q) begin
            active_d  = 1'b1;
            dds_n_d   = n_out_q;
            dds_cts_d = cts_out_q;
            if (!keep_c) begin
                acc_d = '0;
                en_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            idx_q       <= '0;
            pos_q       <= '0;
            gap_q       <= '0;
            bad_q       <= 1'b0;
            n_cap_q     <= '0;
            cts_cap_q   <= '0;
            acr_valid_q <= 1'b0;
            acr_error_q <= 1'b0;
            n_out_q     <= '0;
            cts_out_q   <= '0;
            active_q    <= 1'b0;
            dds_n_q     <= '0;
            dds_cts_q   <= '0;
            acc_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            gap_q       <= gap_d;
            bad_q       <= bad_d;
            n_cap_q     <= n_cap_d;
            cts_cap_q   <= cts_cap_d;
            acr_valid_q <= acr_valid_d;
            acr_error_q <= acr_error_d;
            n_out_q     <= n_out_d;
            cts_out_q   <= cts_out_d;
            active_q    <= active_d;
            dds_n_q     <= dds_n_d;
            dds_cts_q   <= dds_cts_d;
            acc_q       <= acc_d;
            en_q        <= en_d;
        end
    end

    assign acr_valid    = acr_valid_q;
    assign acr_error    = acr_error_q;
    assign n_out        = n_out_q;
    assign cts_out      = cts_out_q;
    assign clk_audio_en = en_q;
endmodule

// File: tb/tb_audio_clock_regeneration_receiver.sv
// Bench for audio_clock_regeneration_receiver: directed scenarios plus random packets,
// checked every cycle against a packet-level model with a closed-form N/CTS pulse rule.
module tb_audio_clock_regeneration_receiver;
    localparam int unsigned MAX_GAP = 64;

    logic        clk_pixel;
    logic        reset_n, pkt_valid, pkt_start;
    logic [7:0]  pkt_data;
    logic        acr_valid, acr_error, clk_audio_en;
    logic [19:0] n_out, cts_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    audio_clock_regeneration_receiver #(.MAX_GAP(MAX_GAP)) dut (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .pkt_valid   (pkt_valid),
        .pkt_start   (pkt_start),
        .pkt_data    (pkt_data),
        .acr_valid   (acr_valid),
        .n_out       (n_out),
        .cts_out     (cts_out),
        .acr_error   (acr_error),
        .clk_audio_en(clk_audio_en)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // ---------------- reference model ----------------
    bit               m_valid, m_err, m_en, m_active, m_collect;
    logic [19:0]      m_n, m_cts, nn, cc;
    longint unsigned  m_dn, m_dc, m_k;
    int               m_gap;
    logic [7:0]       m_bytes[$];

    // Enable on step k of a DDS started from zero: floor(k*N/CTS) increments.
    function automatic bit pulse_at(input longint unsigned k, input longint unsigned n,
                                    input longint unsigned c);
        return ((k * n) / c) != (((k - 1) * n) / c);
    endfunction

    function automatic bit pkt_good(input logic [7:0] b[$], output logic [19:0] n,
                                    output logic [19:0] c);
        bit ok;
        c  = {b[4][3:0], b[5], b[6]};
        n  = {b[7][3:0], b[8], b[9]};
        ok = (b[3] == 8'h00) && (b[4][7:4] == 4'h0) && (b[7][7:4] == 4'h0);
        ok = ok && (n != 20'd0) && (c != 20'd0) && (n < c);
`ifdef ACR_SUBPACKET_CHECK_EN
        for (int j = 10; j < 31; j++) if (b[j] != b[3 + (j - 3) % 7]) ok = 1'b0;
`endif
        return ok;
    endfunction

    always @(posedge clk_pixel) begin
        if (!reset_n) begin
            m_valid = 0; m_err = 0; m_en = 0; m_active = 0; m_collect = 0;
            m_n = '0; m_cts = '0; m_dn = 0; m_dc = 0; m_k = 0; m_gap = 0;
            m_bytes.delete();
        end else begin
            m_en = 0;
            if (m_valid) begin
                if (m_active && m_n == m_dn && m_cts == m_dc) begin
                    m_k++;
                    m_en = pulse_at(m_k, m_dn, m_dc);
                end else begin
                    m_k = 0;
                end
                m_active = 1; m_dn = m_n; m_dc = m_cts;
            end else if (m_active) begin
                m_k++;
                m_en = pulse_at(m_k, m_dn, m_dc);
            end
            m_valid = 0; m_err = 0;
            if (pkt_valid && pkt_start) begin
                m_collect = (pkt_data == 8'h01);
                m_bytes.delete();
                m_bytes.push_back(pkt_data);
                m_gap = 0;
            end else if (m_collect) begin
                if (pkt_valid) begin
                    m_bytes.push_back(pkt_data);
                    m_gap = 0;
                    if (m_bytes.size() == 31) begin
                        if (pkt_good(m_bytes, nn, cc)) begin
                            m_valid = 1; m_n = nn; m_cts = cc;
                        end else begin
                            m_err = 1;
                        end
                        m_collect = 0;
                    end
                end else begin
                    m_gap++;
                    if (m_gap == MAX_GAP) begin
                        m_err = 1; m_collect = 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk_pixel) begin
        if (chk_on) begin
            n_tests++;
            if ({acr_valid, acr_error, clk_audio_en, n_out, cts_out} !==
                {m_valid, m_err, m_en, m_n, m_cts}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got v=%b e=%b en=%b n=%0d cts=%0d expected v=%b e=%b en=%b n=%0d cts=%0d",
                         $time, acr_valid, acr_error, clk_audio_en, n_out, cts_out,
                         m_valid, m_err, m_en, m_n, m_cts);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] pk[31];

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic cyc(input bit v, input bit s, input logic [7:0] d);
        @(negedge clk_pixel);
        pkt_valid = v;
        pkt_start = s;
        pkt_data  = d;
    endtask

    task automatic fill_pkt(input logic [7:0] hb0, input logic [19:0] n, input logic [19:0] c);
        pk[0] = hb0;
        pk[1] = 8'($urandom);
        pk[2] = 8'($urandom);
        for (int s = 0; s < 4; s++) begin
            pk[3 + 7*s] = 8'h00;
            pk[4 + 7*s] = {4'h0, c[19:16]};
            pk[5 + 7*s] = c[15:8];
            pk[6 + 7*s] = c[7:0];
            pk[7 + 7*s] = {4'h0, n[19:16]};
            pk[8 + 7*s] = n[15:8];
            pk[9 + 7*s] = n[7:0];
        end
    endtask

    task automatic send_pkt(input int max_idle, input int stop_at);
        for (int i = 0; i < 31 && i < stop_at; i++) begin
            if (i > 0 && max_idle > 0) repeat ($urandom_range(max_idle, 0)) cyc(1'b0, 1'b0, 8'h00);
            cyc(1'b1, i == 0, pk[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, consec, first, kind, stop;
        bit prev;
        logic [19:0] rn, rc, exp_last_n, exp_last_cts;

        reset_n = 1'b0; pkt_valid = 1'b0; pkt_start = 1'b0; pkt_data = 8'h00;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        chk_on = 1'b1;
        #1;
        check("reset_outputs", 64'({acr_valid, acr_error, clk_audio_en, n_out, cts_out}), 0);
        reset_n = 1'b1;

        // First ACR packet, back-to-back bytes
        fill_pkt(8'h01, 20'd6144, 20'd25200);
        send_pkt(0, 31);
        cyc(1'b0, 1'b0, 8'h00); #1;
        check("acr_valid_after_b30", 64'(acr_valid), 1);
        check("acr_error_first", 64'(acr_error), 0);
        check("n_out_6144", 64'(n_out), 6144);
        check("cts_out_25200", 64'(cts_out), 25200);
        cyc(1'b0, 1'b0, 8'h00); #1;
        check("en_clear_cycle", 64'(clk_audio_en), 0);
        cnt = 0; consec = 0; prev = 1'b0;
        repeat (25200) begin
            cyc(1'b0, 1'b0, 8'h00); #1;
            cnt += int'(clk_audio_en);
            if (prev && clk_audio_en) consec++;
            prev = clk_audio_en;
        end
        check("pulses_in_25200", 64'(cnt), 6144);
        check("consecutive_pulses", 64'(consec), 0);

        // Non-ACR header is silent; next ACR packet clears acc
        fill_pkt(8'h02, 20'd1000, 20'd2000);
        send_pkt(0, 31);
        cnt = 0;
        repeat (3) begin cyc(1'b0, 1'b0, 8'h00); #1; cnt += int'(acr_valid | acr_error); end
        check("skip_pkt_silent", 64'(cnt), 0);
        fill_pkt(8'h01, 20'd4096, 20'd27000);
        send_pkt(0, 31);
        cyc(1'b0, 1'b0, 8'h00); #1;
        check("acr_valid_4096", 64'(acr_valid), 1);
        check("n_out_4096", 64'(n_out), 4096);
        check("cts_out_27000", 64'(cts_out), 27000);
        cyc(1'b0, 1'b0, 8'h00); #1;
        check("en_clear_4096", 64'(clk_audio_en), 0);
        first = 0;
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, 1'b0, 8'h00); #1;
            if (clk_audio_en && first == 0) first = i;
        end
        check("first_pulse_step", 64'(first), 7);

        // Nonzero SB0 in subpacket 2
        fill_pkt(8'h01, 20'd6144, 20'd25200);
        pk[17] = 8'h01;
        send_pkt(0, 31);
        cyc(1'b0, 1'b0, 8'h00); #1;
`ifdef ACR_SUBPACKET_CHECK_EN
        check("sp2_sb0_error", 64'(acr_error), 1);
        check("sp2_sb0_no_valid", 64'(acr_valid), 0);
        check("sp2_sb0_n_hold", 64'(n_out), 4096);
        exp_last_n = 20'd4096; exp_last_cts = 20'd27000;
`else
        check("sp2_sb0_valid", 64'(acr_valid), 1);
        check("sp2_sb0_no_error", 64'(acr_error), 0);
        check("sp2_sb0_n_new", 64'(n_out), 6144);
        exp_last_n = 20'd6144; exp_last_cts = 20'd25200;
`endif

        // Gap abort after byte 10
        fill_pkt(8'h01, 20'd1234, 20'd5678);
        send_pkt(0, 11);
        repeat (MAX_GAP) cyc(1'b0, 1'b0, 8'h00);
        #1;
        check("no_error_before_expiry", 64'(acr_error), 0);
        cyc(1'b1, 1'b0, pk[11]); #1;
        check("gap_expiry_error", 64'(acr_error), 1);
        cnt = 0;
        repeat (40) begin cyc(1'b0, 1'b0, 8'h00); #1; cnt += int'(acr_valid | acr_error); end
        check("after_gap_silent", 64'(cnt), 0);

        // N >= CTS rejected, outputs held
        fill_pkt(8'h01, 20'd30000, 20'd25200);
        send_pkt(0, 31);
        cyc(1'b0, 1'b0, 8'h00); #1;
        check("n_ge_cts_error", 64'(acr_error), 1);
        check("n_ge_cts_no_valid", 64'(acr_valid), 0);
        check("n_ge_cts_n_hold", 64'(n_out), 64'(exp_last_n));
        check("n_ge_cts_cts_hold", 64'(cts_out), 64'(exp_last_cts));
        repeat (100) cyc(1'b0, 1'b0, 8'h00);

        // Reset at byte 20
        fill_pkt(8'h01, 20'd100, 20'd200);
        send_pkt(0, 20);
        cyc(1'b1, 1'b0, pk[20]);
        reset_n = 1'b0;
        cyc(1'b0, 1'b0, 8'h00); #1;
        check("mid_reset_outputs", 64'({acr_valid, acr_error, clk_audio_en, n_out, cts_out}), 0);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 21; i < 31; i++) begin cyc(1'b1, 1'b0, pk[i]); #1; cnt += int'(acr_valid | acr_error); end
        repeat (5) begin cyc(1'b0, 1'b0, 8'h00); #1; cnt += int'(acr_valid | acr_error | clk_audio_en); end
        check("post_reset_silent", 64'(cnt), 0);

        // Randomized packets
        for (int it = 0; it < 160; it++) begin
            kind = int'($urandom_range(10, 0));
            rc = 20'($urandom_range(20'hFFFFF, 2));
            rn = 20'($urandom_range(32'(rc) - 1, 1));
            if (kind == 3 && m_cts != 20'd0) begin rn = m_n; rc = m_cts; end
            if (kind == 5) rn = 20'(32'(rc) + $urandom_range(3, 0));
            if (kind == 9) begin
                if ($urandom_range(1, 0) == 1) rn = 20'd0; else rc = 20'd0;
            end
            fill_pkt(kind == 4 ? 8'($urandom_range(255, 2)) : 8'h01, rn, rc);
            if (kind == 6) pk[$urandom_range(30, 3)] = 8'($urandom);
            stop = 31;
            if (kind == 7 || kind == 8 || kind == 10) stop = int'($urandom_range(29, 2));
            send_pkt(int'($urandom_range(2, 0)), stop);
            if (kind == 8) repeat (MAX_GAP + $urandom_range(5, 0)) cyc(1'b0, 1'b0, 8'h00);
            if (kind == 10) begin
                repeat (MAX_GAP - 1) cyc(1'b0, 1'b0, 8'h00);
                for (int i = stop; i < 31; i++) cyc(1'b1, 1'b0, pk[i]);
            end
            repeat ($urandom_range(5, 0)) begin
                if ($urandom_range(3, 0) == 0) cyc(1'b1, 1'b0, 8'($urandom));
                else cyc(1'b0, 1'($urandom), 8'($urandom));
            end
        end

        repeat (10) cyc(1'b0, 1'b0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_clock_regeneration_receiver.md
AUDIO_CLOCK_REGENERATION_RECEIVER -- requirements
Module: audio_clock_regeneration_receiver

Interface
REQ-001 SHALL have parameter MAX_GAP, default 64: number of consecutive idle clk_pixel cycles mid-packet after which the packet is aborted.
REQ-002 SHALL have port clk_pixel  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port pkt_valid  input  1  pkt_data carries a packet byte this cycle.
REQ-005 SHALL have port pkt_start  input  1  qualified by pkt_valid; marks byte HB0 of a packet.
REQ-006 SHALL have port pkt_data  input  8  packet byte.
REQ-007 SHALL have port acr_valid  output  1  one-cycle pulse: n_out and cts_out were updated.
REQ-008 SHALL have port n_out  output  20  last accepted N.
REQ-009 SHALL have port cts_out  output  20  last accepted CTS.
REQ-010 SHALL have port acr_error  output  1  one-cycle pulse: malformed or aborted ACR packet.
REQ-011 SHALL have port clk_audio_en  output  1  single-cycle enable at average rate f_clk_pixel*N/CTS (128*fs).

Function
REQ-012 SHALL receive 31 bytes per packet, in order: HB0, HB1, HB2, then subpackets 0..3, each sent as SB0..SB6.
REQ-013 SHALL decode each subpacket as: SB0 = 0x00, SB1 = {0000, CTS[19:16]}, SB2 = CTS[15:8], SB3 = CTS[7:0], SB4 = {0000, N[19:16]}, SB5 = N[15:8], SB6 = N[7:0].
REQ-014 SHALL use FSM states IDLE, HEADER, SUB, SKIP and REPORT.
REQ-015 SHALL go to HEADER from any state when pkt_valid & pkt_start, with byte index 0; in IDLE, a valid byte without start SHALL be ignored.
REQ-016 SHALL go to SKIP if HB0 != 0x01, stay in SKIP until the next start, and pulse no output; HB1 and HB2 SHALL be ignored.
REQ-017 SHALL flag the packet bad on: a nonzero SB0; a nonzero upper nibble in SB1 or SB4; N = 0; CTS = 0; or N >= CTS.
REQ-018 SHALL enter REPORT one cycle after byte 30 is accepted, then return to IDLE.
REQ-019 In REPORT with a good packet, SHALL update n_out and cts_out and pulse acr_valid in the same cycle.
REQ-020 In REPORT with a bad packet, SHALL pulse acr_error and hold n_out and cts_out.
REQ-021 SHALL abort to IDLE and pulse acr_error when in HEADER or SUB with no valid byte for MAX_GAP consecutive cycles; the gap counter SHALL clear on every valid byte.
REQ-022 SHALL discard a partial packet without an error pulse when a start arrives mid-packet.
REQ-023 SHALL hold clk_audio_en at 0 until the first acr_valid.
REQ-024 Once active, SHALL run a 21-bit accumulator acc each cycle: if acc+N >= CTS then acc <= acc+N-CTS and clk_audio_en = 1, else acc <= acc+N and clk_audio_en = 0.
REQ-025 On acr_valid, SHALL keep acc if the new N and CTS equal the old values, otherwise clear acc to 0.
REQ-026 SHALL register clk_audio_en as a registered output.
REQ-027 SHALL give the DDS priority over parsing: the accumulator SHALL run uninterrupted while packets are parsed and SHALL switch to the new N and CTS in the cycle after acr_valid.

Reset
REQ-028 While reset_n = 0 at a clk_pixel edge, the block SHALL set: FSM to IDLE; byte index, gap counter and acc to 0; n_out and cts_out to 0; acr_valid, acr_error and clk_audio_en to 0; DDS inactive.
REQ-029 SHALL discard a packet in progress when reset is asserted mid-packet, with no pulse after release.

Configuration
REQ-030 With ACR_SUBPACKET_CHECK_EN defined, SHALL capture N and CTS from subpacket 0 and flag the packet bad if any byte of subpackets 1..3 differs from the corresponding byte of subpacket 0.
REQ-031 Without ACR_SUBPACKET_CHECK_EN, SHALL take N and CTS from subpacket 0 only and ignore the contents of subpackets 1..3 (byte count still enforced).

Verification
REQ-032 SHALL cover: after reset, send an ACR packet with N = 6144 (0x01800) and CTS = 25200 (0x06270), back-to-back -> acr_valid one cycle after byte 30, n_out = 6144, cts_out = 25200, no acr_error.
REQ-033 SHALL cover: after the REQ-032 packet, run 25200 cycles -> exactly 6144 clk_audio_en pulses, never in consecutive cycles.
REQ-034 SHALL cover: a packet with HB0 = 0x02, then a valid ACR packet with N = 4096 and CTS = 27000 -> first packet silent; second gives acr_valid with n_out = 4096, and acc cleared.
REQ-035 SHALL cover: an ACR packet with SB0 = 0x01 in subpacket 2, with the macro defined -> acr_error pulse, n_out and cts_out unchanged; with the macro undefined -> acr_valid.
REQ-036 SHALL cover: pkt_valid dropped for 64 cycles after byte 10 -> acr_error on the gap expiry cycle, FSM IDLE; the following byte without start is ignored.
REQ-037 SHALL cover: an ACR packet with N = 30000 and CTS = 25200 -> acr_error, clk_audio_en continuing at the previous rate; reset_n low at byte 20 -> all outputs 0, no pulse after release.
